// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx one frame at a time.
// Launches a byte with a txDv pulse, then tracks the frame via txActive/txDone.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ACTIVE_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           wrEn,
    input  logic [DATA_WIDTH-1:0]          wrData,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow,
    output logic                           txDv,
    output logic [DATA_WIDTH-1:0]          txByte,
    input  logic                           txActive,
    input  logic                           txDone,
    output logic                           txError
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(ACTIVE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACTIVE = 2'd1,
        WAIT_DONE   = 2'd2
    } stateT;

    stateT                  state;
    stateT                  stateNext;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;
    logic [CW-1:0]          countNext;
    logic [TW-1:0]          timer;
    logic                   doPush;
    logic                   launch;
    logic                   timeoutHit;
    logic                   txDvNext;
    logic                   txErrorNext;
    logic                   overflowNext;

    // A pop only ever happens as part of a launch from IDLE.
    assign launch     = (state == IDLE) && enable && !empty && !txActive;
    assign doPush     = wrEn && !full;
    assign timeoutHit = (state == WAIT_ACTIVE) && !txActive && !txDone
                        && (timer == TW'(ACTIVE_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    stateNext = WAIT_ACTIVE;
                end
            end
            WAIT_ACTIVE: begin
                if (txActive) begin
                    stateNext = WAIT_DONE;
                end else if (txDone || timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            WAIT_DONE: begin
                if (txDone || !txActive) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output logic (values registered below)
    always_comb begin
        txDvNext     = launch;
        txErrorNext  = timeoutHit;
        overflowNext = wrEn && full;
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        countNext = count;
        if (doPush && !launch) begin
            countNext = count + CW'(1);
        end else if (!doPush && launch) begin
            countNext = count - CW'(1);
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            txDv     <= 1'b0;
            txByte   <= '0;
            txError  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (launch) begin
                rdPtr  <= rdPtr + AW'(1);
                txByte <= mem[rdPtr];
            end
            count    <= countNext;
            full     <= (countNext == CW'(DEPTH));
            empty    <= (countNext == '0);
            overflow <= overflowNext;
            txDv     <= txDvNext;
            txError  <= txErrorNext;
        end
    end

    // Cycles spent waiting for txActive after a launch
    always_ff @(posedge clk) begin
        if (reset || (state != WAIT_ACTIVE)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small uart_tx stand-in driven on the falling edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       txDv;
    logic [7:0] txByte;
    logic       txActive = 1'b0;
    logic       txDone = 1'b0;
    logic       txError;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] launched[$];
    int stubMode = 0;
    int frameLen = 4;
    int remain = 0;
    bit busy = 1'b0;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ACTIVE_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wrEn(wrEn), .wrData(wrData),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .txDv(txDv), .txByte(txByte), .txActive(txActive), .txDone(txDone),
        .txError(txError)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: mode 0 runs a frameLen-cycle frame, mode 1 never responds.
    always @(negedge clk) begin
        txDone = 1'b0;
        if (txDv) launched.push_back(txByte);
        if (stubMode == 0) begin
            if (busy) begin
                if (remain <= 1) begin
                    txActive = 1'b0;
                    txDone   = 1'b1;
                    busy     = 1'b0;
                end else begin
                    remain = remain - 1;
                end
            end else if (txDv) begin
                busy     = 1'b1;
                txActive = 1'b1;
                remain   = frameLen;
            end
        end
    end

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (empty && !txActive && !busy && !txDv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
        vectors++; if (txDv !== 1'b0 || txError !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got dv=%b err=%b ovf=%b want 0", txDv, txError, overflow); end
        vectors++; if (txByte !== 8'h00) begin miscompares++; $display("FAIL reset_txbyte got %h want 00", txByte); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency();
        bit ok;
        launched.delete();
        @(negedge clk); wrEn = 1'b1; wrData = 8'h07;
        @(posedge clk); #1;
        vectors++; if (count !== 5'd1 || txDv !== 1'b0) begin miscompares++; $display("FAIL lat_write got count=%0d dv=%b want 1/0", count, txDv); end
        @(negedge clk); wrEn = 1'b0;
        @(posedge clk); #1;
        vectors++; if (txDv !== 1'b1 || txByte !== 8'h07) begin miscompares++; $display("FAIL lat_launch got dv=%b byte=%h want 1/07", txDv, txByte); end
        vectors++; if (count !== 5'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL lat_pop got count=%0d empty=%b want 0/1", count, empty); end
        @(posedge clk); #1;
        vectors++; if (txDv !== 1'b0 || txByte !== 8'h07) begin miscompares++; $display("FAIL lat_hold got dv=%b byte=%h want 0/07", txDv, txByte); end
        drain(100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL lat_drain got timeout want idle"); end
        vectors++; if (launched.size() != 1 || launched[0] !== 8'h07) begin miscompares++; $display("FAIL lat_frames got %0d frames want 1 of 07", launched.size()); end
    endtask

    task automatic test_burst();
        bit ok;
        enable = 1'b0;
        launched.delete();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); wrEn = 1'b1; wrData = 8'(i);
        end
        @(posedge clk); #1;
        vectors++; if (full !== 1'b1 || count !== 5'd16) begin miscompares++; $display("FAIL burst_full got full=%b count=%0d want 1/16", full, count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL burst_noovf got %b want 0", overflow); end
        // 17th write lands on the same edge as the first pop: still dropped.
        @(negedge clk); enable = 1'b1; wrData = 8'h11;
        @(posedge clk); #1;
        vectors++; if (overflow !== 1'b1 || count !== 5'd15) begin miscompares++; $display("FAIL burst_ovf got ovf=%b count=%0d want 1/15", overflow, count); end
        vectors++; if (txDv !== 1'b1 || txByte !== 8'h01 || full !== 1'b0) begin miscompares++; $display("FAIL burst_launch got dv=%b byte=%h full=%b want 1/01/0", txDv, txByte, full); end
        @(negedge clk); wrEn = 1'b0;
        @(posedge clk); #1;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL burst_ovfpulse got %b want 0", overflow); end
        drain(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL burst_drain got timeout want idle"); end
        vectors++; if (launched.size() != 16) begin miscompares++; $display("FAIL burst_frames got %0d want 16", launched.size()); end
        for (int i = 0; i < launched.size() && i < 16; i++) begin
            vectors++; if (launched[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL burst_order[%0d] got %h want %h", i, launched[i], 8'(i + 1)); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL burst_empty got %b want 1", empty); end
    endtask

    task automatic test_simul();
        bit ok;
        bit lost;
        int k;
        enable = 1'b0;
        launched.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wrEn = 1'b1; wrData = 8'(i * 7 + 3);
        end
        @(negedge clk); wrEn = 1'b1; wrData = 8'(5 * 7 + 3); enable = 1'b1;
        @(posedge clk); #1;
        vectors++; if (count !== 5'd5 || txDv !== 1'b1) begin miscompares++; $display("FAIL simul_first got count=%0d dv=%b want 5/1", count, txDv); end
        k = 6;
        lost = 1'b0;
        while (k < 53 && !lost) begin
            @(negedge clk); wrEn = 1'b0;
            lost = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                if (txDone) begin lost = 1'b0; break; end
            end
            if (lost) begin
                vectors++; miscompares++; $display("FAIL simul_wait got no txDone want frame end");
            end else begin
                @(negedge clk); wrEn = 1'b1; wrData = 8'(k * 7 + 3);
                @(posedge clk); #1;
                vectors++; if (count !== 5'd5 || txDv !== 1'b1) begin miscompares++; $display("FAIL simul_step%0d got count=%0d dv=%b want 5/1", k, count, txDv); end
                k++;
            end
        end
        @(negedge clk); wrEn = 1'b0;
        drain(200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL simul_drain got timeout want idle"); end
        vectors++; if (launched.size() != 53) begin miscompares++; $display("FAIL simul_frames got %0d want 53", launched.size()); end
        for (int j = 0; j < launched.size() && j < 53; j++) begin
            vectors++; if (launched[j] !== 8'(j * 7 + 3)) begin miscompares++; $display("FAIL simul_data[%0d] got %h want %h", j, launched[j], 8'(j * 7 + 3)); end
        end
    endtask

    task automatic test_enable();
        bit ok;
        int dv;
        enable = 1'b0;
        launched.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wrEn = 1'b1; wrData = 8'(8'h41 + i);
        end
        @(negedge clk); wrEn = 1'b0;
        dv = 0;
        repeat (10) begin @(posedge clk); #1; if (txDv) dv++; end
        vectors++; if (dv != 0 || count !== 5'd3) begin miscompares++; $display("FAIL enable_hold got pulses=%0d count=%0d want 0/3", dv, count); end
        @(negedge clk); enable = 1'b1;
        drain(100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL enable_drain got timeout want idle"); end
        vectors++; if (launched.size() != 3) begin miscompares++; $display("FAIL enable_frames got %0d want 3", launched.size()); end
        for (int i = 0; i < launched.size() && i < 3; i++) begin
            vectors++; if (launched[i] !== 8'(8'h41 + i)) begin miscompares++; $display("FAIL enable_data[%0d] got %h want %h", i, launched[i], 8'(8'h41 + i)); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int early;
        enable = 1'b0;
        stubMode = 1;
        launched.delete();
        @(negedge clk); wrEn = 1'b1; wrData = 8'hA5;
        @(negedge clk); wrEn = 1'b1; wrData = 8'h5A;
        @(negedge clk); wrEn = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        vectors++; if (txDv !== 1'b1 || txByte !== 8'hA5) begin miscompares++; $display("FAIL to_launch got dv=%b byte=%h want 1/a5", txDv, txByte); end
        early = 0;
        repeat (15) begin @(posedge clk); #1; if (txError || txDv) early++; end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL to_early got %0d pulses want 0", early); end
        @(posedge clk); #1;
        vectors++; if (txError !== 1'b1 || count !== 5'd1) begin miscompares++; $display("FAIL to_error got err=%b count=%0d want 1/1", txError, count); end
        @(negedge clk); stubMode = 0;
        @(posedge clk); #1;
        vectors++; if (txDv !== 1'b1 || txByte !== 8'h5A || txError !== 1'b0) begin miscompares++; $display("FAIL to_next got dv=%b byte=%h err=%b want 1/5a/0", txDv, txByte, txError); end
        drain(100, ok);
        vectors++; if (!ok || launched.size() != 2) begin miscompares++; $display("FAIL to_frames got ok=%b n=%0d want 1/2", ok, launched.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int early;
        bit fell;
        enable = 1'b0;
        frameLen = 30;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wrEn = 1'b1; wrData = 8'(8'h31 + i);
        end
        @(negedge clk); wrEn = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        vectors++; if (txDv !== 1'b1 || count !== 5'd4) begin miscompares++; $display("FAIL rst_launch got dv=%b count=%0d want 1/4", txDv, count); end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1; launched.delete();
        @(posedge clk); #1;
        vectors++; if (count !== 5'd0 || empty !== 1'b1 || txDv !== 1'b0) begin miscompares++; $display("FAIL rst_clear got count=%0d empty=%b dv=%b want 0/1/0", count, empty, txDv); end
        @(negedge clk); reset = 1'b0; wrEn = 1'b1; wrData = 8'hAB;
        @(posedge clk); #1;
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL rst_write got %0d want 1", count); end
        @(negedge clk); wrEn = 1'b0;
        early = 0;
        fell = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (!txActive) begin fell = 1'b1; break; end
            if (txDv) early++;
        end
        vectors++; if (!fell || early != 0) begin miscompares++; $display("FAIL rst_guard got fell=%b early=%0d want 1/0", fell, early); end
        vectors++; if (txDv !== 1'b1 || txByte !== 8'hAB) begin miscompares++; $display("FAIL rst_relaunch got dv=%b byte=%h want 1/ab", txDv, txByte); end
        drain(100, ok);
        vectors++; if (!ok || launched.size() != 1) begin miscompares++; $display("FAIL rst_frames got ok=%b n=%0d want 1/1", ok, launched.size()); end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        wrEn   = 1'b0;
        wrData = 8'h00;
        test_reset();
        test_latency();
        test_burst();
        test_simul();
        test_enable();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
